module_lector_teclado: RTL and testbench
========================================

// Module: module_lector_teclado
// PURPOSE
//  Input side of the multiplier datapath: scans a 4x4 matrix keypad, debounces it and decodes keys.
//  Captures the two 4-bit operands a_bin/b_bin that feed the display/multiplier path.
//  Emits a one-cycle start pulse and a display select code (sel) for the 7-segment display block.
// PARAMETERS
//  SCAN_DIV      1000   clk cycles each column stays driven while scanning (>=2)
//  DEBOUNCE_CNT  10000  consecutive identical samples required for press and for release (>=2)
// PORTS
//  clk        in   1  system clock
//  rst        in   1  asynchronous reset, active-low
//  filas      in   4  keypad rows, active-low, pulled up externally
//  columnas   out  4  keypad columns, one-hot active-low drive
//  key_code   out  4  code of last accepted key (held until next accept)
//  key_valid  out  1  1-cycle pulse when a debounced press is accepted
//  a_bin      out  4  operand A
//  b_bin      out  4  operand B
//  start      out  1  1-cycle pulse: both operands confirmed
//  sel        out  3  display select: 001 = show A, 010 = show B, 100 = show product
// BEHAVIOUR
//  Reset values
//   columnas=1110, key_code=0, key_valid=0, a_bin=0, b_bin=0, start=0, sel=001.
//   Scanner enters SCAN; capture FSM enters CAP_A.
//  Row synchronizer
//   filas passes through a synchronizer before any use; rows_s is the synchronized value.
//  Scanner FSM: SCAN, DEBOUNCE, ACCEPT, WAIT_REL
//   SCAN: columnas rotates 1110->1101->1011->0111->1110, one step every SCAN_DIV cycles.
//    If rows_s != 1111: freeze the column, latch rows_s, go to DEBOUNCE.
//   DEBOUNCE: counts cycles where rows_s equals the latched pattern.
//    Any mismatch returns to SCAN without a pulse; the column resumes from the frozen one.
//    After DEBOUNCE_CNT matching cycles: go to ACCEPT.
//   ACCEPT (1 cycle): key_valid=1 and key_code updates in the same cycle; go to WAIT_REL.
//   WAIT_REL: needs DEBOUNCE_CNT consecutive cycles of rows_s==1111, then returns to SCAN.
//    Any low row resets the release count; a held key never repeats.
//  Multiple rows low: the lowest row index wins. Columns are never driven two-at-a-time.
//  Key map (row r, column c -> key_code)
//   r0: 1 2 3 A -> 1,2,3,A
//   r1: 4 5 6 B -> 4,5,6,B
//   r2: 7 8 9 C -> 7,8,9,C
//   r3: * 0 # D -> E,0,F,D
//   Data keys: codes 0-D. Clear '*' = E. Enter '#' = F.
//  Capture FSM: CAP_A, CAP_B, DONE (advances only on key_valid)
//   CAP_A, sel=001
//    Data key: a_bin <= code (last key wins) and sets flag a_ok.
//    '#': go to CAP_B only if a_ok; otherwise ignored.
//   CAP_B, sel=010: same rules on b_bin/b_ok.
//    '#' with b_ok: go to DONE; start=1 on the cycle after that key_valid.
//   DONE, sel=100: data keys and '#' ignored; a_bin/b_bin held.
//   '*' in any state: a_bin=b_bin=0, flags cleared, go to CAP_A (start not pulsed).
//  start and key_valid are never high for more than one consecutive cycle.
//  Reset mid-operation: all state and outputs return immediately to reset values.
//  Counters are sized $clog2 of their parameter and saturate. No wrap inside DEBOUNCE or WAIT_REL.
// CONFIGURATION
//  SYNC2_STAGE_EN defined: 2-flop synchronizer on filas.
//   Press-to-key_valid latency = 2 + DEBOUNCE_CNT + 1 cycles from the first low sample on filas.
//  SYNC2_STAGE_EN undefined: 1-flop synchronizer; the same latency is 1 cycle shorter.
//  All other behaviour is identical.
// TESTING (SCAN_DIV=4, DEBOUNCE_CNT=8, SYNC2_STAGE_EN defined)
//  1. Idle rows=1111 after reset -> columnas cycles 1110,1101,1011,0111, 4 clks each; no key_valid.
//  2. Hold r1 low while columnas=1011 -> single key_valid with key_code=6, exactly 11 clks after filas
//     falls; no repeat while held.
//  3. Bounce: r0 low 3 clks, high 1, low steady -> no pulse during bounce; one key_valid after the
//     steady 8-sample window.
//  4. Keys 3,5,#,9,# -> a_bin=5, b_bin=9; sel 001->010->100; start high exactly 1 cycle after the
//     second '#'.
//  5. '#' in CAP_A with no digit -> ignored, sel stays 001. '*' in DONE -> a_bin=b_bin=0, sel=001.
//  6. rst low mid-DEBOUNCE and again in DONE -> all outputs at reset values immediately, asynchronously.

Source files
------------

// File: rtl/module_lector_teclado.sv
// Keypad front end: scans a 4x4 matrix, debounces, decodes keys and captures operands A/B.
// Define SYNC2_STAGE_EN for a 2-flop row synchronizer (default build uses 1 flop).
module module_lector_teclado #(
   parameter int unsigned SCAN_DIV     = 1000,
   parameter int unsigned DEBOUNCE_CNT = 10000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] filas,
   output logic [3:0] columnas,
   output logic [3:0] key_code,
   output logic       key_valid,
   output logic [3:0] a_bin,
   output logic [3:0] b_bin,
   output logic       start,
   output logic [2:0] sel
);

   localparam int unsigned     SC_W      = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int unsigned     DB_W      = (DEBOUNCE_CNT > 1) ? $clog2(DEBOUNCE_CNT) : 1;
   localparam logic [SC_W-1:0] SC_MAX    = SC_W'(SCAN_DIV - 1);
   localparam logic [DB_W-1:0] DB_MAX    = DB_W'(DEBOUNCE_CNT - 1);
   localparam logic [3:0]      ROWS_IDLE = 4'b1111;
   localparam logic [3:0]      COL_FIRST = 4'b1110;
   localparam logic [3:0]      KEY_CLEAR = 4'hE;
   localparam logic [3:0]      KEY_ENTER = 4'hF;
   localparam logic [2:0]      SEL_A     = 3'b001;
   localparam logic [2:0]      SEL_B     = 3'b010;
   localparam logic [2:0]      SEL_P     = 3'b100;

   typedef enum logic [1:0] {
      SCAN     = 2'd0,
      DEBOUNCE = 2'd1,
      ACCEPT   = 2'd2,
      WAIT_REL = 2'd3
   } scan_state_e;

   typedef enum logic [1:0] {
      CAP_A = 2'd0,
      CAP_B = 2'd1,
      DONE  = 2'd2
   } cap_state_e;

   // Lowest-index low row wins when several rows are pulled down.
   function automatic logic [1:0] row_idx(input logic [3:0] rows);
      if (!rows[0])      row_idx = 2'd0;
      else if (!rows[1]) row_idx = 2'd1;
      else if (!rows[2]) row_idx = 2'd2;
      else               row_idx = 2'd3;
   endfunction

   function automatic logic [1:0] col_idx(input logic [3:0] col);
      if (!col[0])      col_idx = 2'd0;
      else if (!col[1]) col_idx = 2'd1;
      else if (!col[2]) col_idx = 2'd2;
      else              col_idx = 2'd3;
   endfunction

   function automatic logic [3:0] decode_key(input logic [1:0] r, input logic [1:0] c);
      case ({r, c})
         4'b00_00: decode_key = 4'h1;
         4'b00_01: decode_key = 4'h2;
         4'b00_10: decode_key = 4'h3;
         4'b00_11: decode_key = 4'hA;
         4'b01_00: decode_key = 4'h4;
         4'b01_01: decode_key = 4'h5;
         4'b01_10: decode_key = 4'h6;
         4'b01_11: decode_key = 4'hB;
         4'b10_00: decode_key = 4'h7;
         4'b10_01: decode_key = 4'h8;
         4'b10_10: decode_key = 4'h9;
         4'b10_11: decode_key = 4'hC;
         4'b11_00: decode_key = KEY_CLEAR;
         4'b11_01: decode_key = 4'h0;
         4'b11_10: decode_key = KEY_ENTER;
         default:  decode_key = 4'hD;
      endcase
   endfunction

   // Row synchronizer; the driven column is delayed alongside so rows_s is paired with its column.
   logic [3:0] sync1_q, sync1_d;
   logic [3:0] colp1_q, colp1_d;
   logic [3:0] rows_s;
   logic [3:0] col_s;
   logic [3:0] col_q, col_d;

   always_comb begin
      sync1_d = filas;
      colp1_d = col_q;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1_q <= ROWS_IDLE;
         colp1_q <= COL_FIRST;
      end else begin
         sync1_q <= sync1_d;
         colp1_q <= colp1_d;
      end
   end

`ifdef SYNC2_STAGE_EN
   logic [3:0] sync2_q, sync2_d;
   logic [3:0] colp2_q, colp2_d;

   always_comb begin
      sync2_d = sync1_q;
      colp2_d = colp1_q;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync2_q <= ROWS_IDLE;
         colp2_q <= COL_FIRST;
      end else begin
         sync2_q <= sync2_d;
         colp2_q <= colp2_d;
      end
   end

   assign rows_s = sync2_q;
   assign col_s  = colp2_q;
`else
   assign rows_s = sync1_q;
   assign col_s  = colp1_q;
`endif

   // Scanner FSM state and datapath.
   scan_state_e     scan_state_q, scan_state_d;
   logic [SC_W-1:0] scan_cnt_q, scan_cnt_d;
   logic [DB_W-1:0] db_cnt_q, db_cnt_d;
   logic [3:0]      rows_lat_q, rows_lat_d;
   logic [3:0]      key_code_q, key_code_d;
   logic            key_valid_q, key_valid_d;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         scan_state_q <= SCAN;
         col_q        <= COL_FIRST;
         scan_cnt_q   <= '0;
         db_cnt_q     <= '0;
         rows_lat_q   <= ROWS_IDLE;
         key_code_q   <= '0;
         key_valid_q  <= 1'b0;
      end else begin
         scan_state_q <= scan_state_d;
         col_q        <= col_d;
         scan_cnt_q   <= scan_cnt_d;
         db_cnt_q     <= db_cnt_d;
         rows_lat_q   <= rows_lat_d;
         key_code_q   <= key_code_d;
         key_valid_q  <= key_valid_d;
      end
   end

   always_comb begin
      scan_state_d = scan_state_q;
      col_d        = col_q;
      scan_cnt_d   = scan_cnt_q;
      db_cnt_d     = db_cnt_q;
      rows_lat_d   = rows_lat_q;
      key_code_d   = key_code_q;
      key_valid_d  = 1'b0;

      case (scan_state_q)
         SCAN: begin
            // Rows only count once the synchronizer reflects the column currently driven.
            if ((rows_s != ROWS_IDLE) && (col_s == col_q)) begin
               scan_state_d = DEBOUNCE;
               rows_lat_d   = rows_s;
               db_cnt_d     = '0;
               scan_cnt_d   = '0;
            end else if (scan_cnt_q == SC_MAX) begin
               scan_cnt_d = '0;
               col_d      = {col_q[2:0], col_q[3]};
            end else begin
               scan_cnt_d = scan_cnt_q + SC_W'(1);
            end
         end

         DEBOUNCE: begin
            if (rows_s != rows_lat_q) begin
               scan_state_d = SCAN;
            end else if (db_cnt_q == DB_MAX) begin
               scan_state_d = ACCEPT;
               key_valid_d  = 1'b1;
               key_code_d   = decode_key(row_idx(rows_lat_q), col_idx(col_q));
            end else begin
               db_cnt_d = db_cnt_q + DB_W'(1);
            end
         end

         ACCEPT: begin
            scan_state_d = WAIT_REL;
            db_cnt_d     = '0;
         end

         WAIT_REL: begin
            if (rows_s != ROWS_IDLE) begin
               db_cnt_d = '0;
            end else if (db_cnt_q == DB_MAX) begin
               scan_state_d = SCAN;
               scan_cnt_d   = '0;
            end else begin
               db_cnt_d = db_cnt_q + DB_W'(1);
            end
         end

         default: begin
            scan_state_d = SCAN;
         end
      endcase
   end

   // Capture FSM: consumes accepted keys to build operands A and B.
   cap_state_e cap_state_q, cap_state_d;
   logic [3:0] a_q, a_d;
   logic [3:0] b_q, b_d;
   logic       a_ok_q, a_ok_d;
   logic       b_ok_q, b_ok_d;
   logic       start_q, start_d;
   logic [2:0] sel_q, sel_d;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cap_state_q <= CAP_A;
         a_q         <= '0;
         b_q         <= '0;
         a_ok_q      <= 1'b0;
         b_ok_q      <= 1'b0;
         start_q     <= 1'b0;
         sel_q       <= SEL_A;
      end else begin
         cap_state_q <= cap_state_d;
         a_q         <= a_d;
         b_q         <= b_d;
         a_ok_q      <= a_ok_d;
         b_ok_q      <= b_ok_d;
         start_q     <= start_d;
         sel_q       <= sel_d;
      end
   end

   always_comb begin
      cap_state_d = cap_state_q;
      a_d         = a_q;
      b_d         = b_q;
      a_ok_d      = a_ok_q;
      b_ok_d      = b_ok_q;
      start_d     = 1'b0;
      sel_d       = SEL_A;

      if (key_valid_q) begin
         if (key_code_q == KEY_CLEAR) begin
            cap_state_d = CAP_A;
            a_d         = '0;
            b_d         = '0;
            a_ok_d      = 1'b0;
            b_ok_d      = 1'b0;
         end else begin
            case (cap_state_q)
               CAP_A: begin
                  if (key_code_q == KEY_ENTER) begin
                     if (a_ok_q) cap_state_d = CAP_B;
                  end else begin
                     a_d    = key_code_q;
                     a_ok_d = 1'b1;
                  end
               end
               CAP_B: begin
                  if (key_code_q == KEY_ENTER) begin
                     if (b_ok_q) begin
                        cap_state_d = DONE;
                        start_d     = 1'b1;
                     end
                  end else begin
                     b_d    = key_code_q;
                     b_ok_d = 1'b1;
                  end
               end
               DONE: begin
                  cap_state_d = DONE;
               end
               default: begin
                  cap_state_d = CAP_A;
               end
            endcase
         end
      end

      case (cap_state_d)
         CAP_B:   sel_d = SEL_B;
         DONE:    sel_d = SEL_P;
         default: sel_d = SEL_A;
      endcase
   end

   assign columnas  = col_q;
   assign key_code  = key_code_q;
   assign key_valid = key_valid_q;
   assign a_bin     = a_q;
   assign b_bin     = b_q;
   assign start     = start_q;
   assign sel       = sel_q;

endmodule

// File: tb/tb_module_lector_teclado.sv
// Bench for module_lector_teclado: keypad model driven by the scanned columns, directed and random keys
// checked against an operand-capture reference model.
module tb_module_lector_teclado;

   localparam int SCAN_DIV     = 4;
   localparam int DEBOUNCE_CNT = 8;
`ifdef SYNC2_STAGE_EN
   localparam int LAT = 2 + DEBOUNCE_CNT + 1;
`else
   localparam int LAT = 1 + DEBOUNCE_CNT + 1;
`endif
   localparam int BOUND    = 200;
   localparam int REL_WAIT = 20;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] filas;
   logic [3:0] columnas;
   logic [3:0] key_code;
   logic       key_valid;
   logic [3:0] a_bin;
   logic [3:0] b_bin;
   logic       start;
   logic [2:0] sel;

   logic       key_down = 1'b0;
   logic [1:0] key_r    = 2'd0;
   logic [1:0] key_c    = 2'd0;

   int n_pass  = 0;
   int n_fail  = 0;
   int n_total = 0;

   // Reference: key map (index r*4+c) and capture state.
   logic [3:0] km [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                           4'h4, 4'h5, 4'h6, 4'hB,
                           4'h7, 4'h8, 4'h9, 4'hC,
                           4'hE, 4'h0, 4'hF, 4'hD};
   int         m_st  = 0;
   logic [3:0] m_a   = 4'h0;
   logic [3:0] m_b   = 4'h0;
   bit         m_aok = 1'b0;
   bit         m_bok = 1'b0;

   module_lector_teclado #(
      .SCAN_DIV     (SCAN_DIV),
      .DEBOUNCE_CNT (DEBOUNCE_CNT)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .filas     (filas),
      .columnas  (columnas),
      .key_code  (key_code),
      .key_valid (key_valid),
      .a_bin     (a_bin),
      .b_bin     (b_bin),
      .start     (start),
      .sel       (sel)
   );

   always #5 clk = ~clk;

   // Physical keypad: a pressed key pulls its row low only while its column is driven low.
   always_comb begin
      filas = 4'hF;
      if (key_down && (columnas[key_c] == 1'b0)) filas[key_r] = 1'b0;
   end

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_st = 0; m_a = 4'h0; m_b = 4'h0; m_aok = 1'b0; m_bok = 1'b0;
   endtask

   task automatic model_key(input logic [3:0] k, output logic st);
      st = 1'b0;
      if (k == 4'hE) begin
         model_reset();
      end else if (m_st == 0) begin
         if (k == 4'hF) begin
            if (m_aok) m_st = 1;
         end else begin
            m_a = k; m_aok = 1'b1;
         end
      end else if (m_st == 1) begin
         if (k == 4'hF) begin
            if (m_bok) begin m_st = 2; st = 1'b1; end
         end else begin
            m_b = k; m_bok = 1'b1;
         end
      end
   endtask

   function automatic logic [2:0] m_sel();
      if (m_st == 0) return 3'b001;
      if (m_st == 1) return 3'b010;
      return 3'b100;
   endfunction

   task automatic check_reset(input string tag);
      check({tag, " columnas"},  16'(columnas),  16'h000E);
      check({tag, " key_code"},  16'(key_code),  16'h0);
      check({tag, " key_valid"}, 16'(key_valid), 16'h0);
      check({tag, " a_bin"},     16'(a_bin),     16'h0);
      check({tag, " b_bin"},     16'(b_bin),     16'h0);
      check({tag, " start"},     16'(start),     16'h0);
      check({tag, " sel"},       16'(sel),       16'h1);
   endtask

   // Returns at the first negedge on which the given column has just become driven.
   task automatic wait_col(input logic [3:0] col);
      int n;
      n = 0;
      while (n < BOUND && columnas === col) begin @(negedge clk); n++; end
      while (n < BOUND && columnas !== col) begin @(negedge clk); n++; end
      check("wait_col", 16'(columnas), 16'(col));
   endtask

   // Press key (r,c) now, wait for acceptance, hold, release and verify the capture outputs.
   task automatic key_txn(input int r, input int c, input int exp_lat, input int hold, input string tag);
      int         lat;
      int         extra;
      int         h;
      logic [3:0] k;
      logic       exp_start;
      k        = km[r*4 + c];
      key_r    = 2'(r);
      key_c    = 2'(c);
      key_down = 1'b1;
      lat      = 0;
      while (lat < BOUND && key_valid !== 1'b1) begin @(posedge clk); #1; lat++; end
      check({tag, " key_valid seen"}, 16'(key_valid), 16'h1);
      if (exp_lat > 0) check({tag, " latency"}, 16'(lat), 16'(exp_lat));
      check({tag, " key_code"}, 16'(key_code), 16'(k));
      model_key(k, exp_start);
      @(posedge clk); #1;
      check({tag, " key_valid 1-cycle"}, 16'(key_valid), 16'h0);
      check({tag, " start"}, 16'(start), 16'(exp_start));
      check({tag, " a_bin"}, 16'(a_bin), 16'(m_a));
      check({tag, " b_bin"}, 16'(b_bin), 16'(m_b));
      check({tag, " sel"},   16'(sel),   16'(m_sel()));
      h = (hold > 0) ? hold : int'($urandom_range(3, 12));
      extra = 0;
      for (int i = 0; i < h; i++) begin
         @(posedge clk); #1;
         extra += int'(key_valid) + int'(start);
      end
      key_down = 1'b0;
      for (int i = 0; i < REL_WAIT; i++) begin
         @(posedge clk); #1;
         extra += int'(key_valid) + int'(start);
      end
      check({tag, " no repeat"}, 16'(extra), 16'h0);
   endtask

   initial begin
      int         quiet;
      int         x;
      int         rr;
      int         cc;
      logic [3:0] exp_col;

      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_reset("rst_init");
      @(negedge clk);
      rst = 1'b1;

      // Idle scan: each column held for SCAN_DIV clocks, no key accepted.
      quiet = 0;
      for (int k = 1; k <= 4 * SCAN_DIV; k++) begin
         @(posedge clk); #1;
         exp_col = ~(4'b0001 << ((k / SCAN_DIV) % 4));
         check("idle columnas", 16'(columnas), 16'(exp_col));
         quiet += int'(key_valid);
      end
      check("idle no key_valid", 16'(quiet), 16'h0);

      // r1 held in column 2: key 6, fixed latency, no repeat.
      wait_col(4'b1011);
      key_txn(1, 2, LAT, 30, "hold6");

      // Bounce on r0 in column 0: 3 low, 1 high, then steady.
      wait_col(4'b1110);
      key_r = 2'd0; key_c = 2'd0; key_down = 1'b1;
      quiet = 0;
      repeat (3) begin @(posedge clk); #1; quiet += int'(key_valid); end
      @(negedge clk);
      key_down = 1'b0;
      @(posedge clk); #1; quiet += int'(key_valid);
      @(negedge clk);
      key_txn(0, 0, LAT, 0, "bounce");
      check("bounce quiet", 16'(quiet), 16'h0);

      // Keys 3,5,#,9,#.
      key_txn(0, 2, 0, 0, "k3");
      key_txn(1, 1, 0, 0, "k5");
      key_txn(3, 2, 0, 0, "enterA");
      key_txn(2, 2, 0, 0, "k9");
      key_txn(3, 2, 0, 0, "enterB");
      check("done a_bin", 16'(a_bin), 16'h5);
      check("done b_bin", 16'(b_bin), 16'h9);
      check("done sel",   16'(sel),   16'h4);

      // Clear in DONE, then Enter with no digit.
      key_txn(3, 0, 0, 0, "clear_done");
      check("clear a_bin", 16'(a_bin), 16'h0);
      check("clear b_bin", 16'(b_bin), 16'h0);
      check("clear sel",   16'(sel),   16'h1);
      key_txn(3, 2, 0, 0, "enter_empty");
      check("enter_empty sel", 16'(sel), 16'h1);

      // Random keys, biased towards Enter and Clear to reach every capture state.
      for (int n = 0; n < 30; n++) begin
         x = int'($urandom_range(0, 99));
         if (x < 25)      begin rr = 3; cc = 2; end
         else if (x < 32) begin rr = 3; cc = 0; end
         else begin
            rr = int'($urandom_range(0, 3));
            cc = int'($urandom_range(0, 3));
         end
         key_txn(rr, cc, 0, 0, $sformatf("rnd%0d", n));
      end

      // Reset while debouncing a key, with A loaded.
      key_txn(3, 0, 0, 0, "pre_clear");
      key_txn(2, 0, 0, 0, "pre_k7");
      check("pre a_bin", 16'(a_bin), 16'h7);
      wait_col(4'b1101);
      key_r = 2'd2; key_c = 2'd1; key_down = 1'b1;
      repeat (5) @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      check_reset("rst_debounce");
      model_reset();
      key_down = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;

      // Reset while in DONE.
      key_txn(0, 2, 0, 0, "r_k3");
      key_txn(1, 1, 0, 0, "r_k5");
      key_txn(3, 2, 0, 0, "r_enterA");
      key_txn(2, 2, 0, 0, "r_k9");
      key_txn(3, 2, 0, 0, "r_enterB");
      check("pre-rst sel", 16'(sel), 16'h4);
      @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      check_reset("rst_done");
      model_reset();
      repeat (2) @(posedge clk);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
